// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared types and constants for the IF/MEM RAM bus arbiter.
package mem_bus_arbiter_pkg;

  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        WRITE_ENABLE = 1'b1;

  // Bit positions in the ctrl stall vector that hold the requesting stages
  localparam int STALL_IF  = 1;
  localparam int STALL_MEM = 4;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_BUS_I  = 3'd1,
    ARB_BUS_D  = 3'd2,
    ARB_HOLD_I = 3'd3,
    ARB_HOLD_D = 3'd4
  } arb_state_e;

  function automatic logic arb_on_bus(input arb_state_e s);
    return (s == ARB_BUS_I) || (s == ARB_BUS_D);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: Wishbone-style single-port RAM bus between the arbiter and the RAM.
interface mem_bus_arbiter_if;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [31:0] m_addr_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_wdata_o;
  logic [31:0] m_rdata_i;
  logic        m_ack_i;

  modport master (
    output m_cyc_o, m_stb_o, m_we_o, m_addr_o, m_sel_o, m_wdata_o,
    input  m_rdata_i, m_ack_i
  );

  modport slave (
    input  m_cyc_o, m_stb_o, m_we_o, m_addr_o, m_sel_o, m_wdata_o,
    output m_rdata_i, m_ack_i
  );
endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// arb_watchdog: bus-cycle timeout counter for mem_bus_arbiter.
// Only present in builds with ARB_TIMEOUT_EN defined; the default build has no counter logic.
`ifdef ARB_TIMEOUT_EN
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_expire
);
  import mem_bus_arbiter_pkg::*;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_cnt;

  // Counter sits at zero outside a bus cycle so every transaction starts from 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE)  r_cnt <= 16'd0;
    else if (!i_busy)       r_cnt <= 16'd0;
    else if (!i_ack)        r_cnt <= r_cnt + 16'd1;
  end

  assign o_expire = i_busy & ~i_ack & (r_cnt == LIMIT);
endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port RAM bus between instruction fetch (IF)
// and data access (MEM), data port has fixed priority. Optional bus timeout
// watchdog is enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall_i,
  input  logic                   flush_i,
  input  logic                   i_ce_i,
  input  logic [31:0]            i_addr_i,
  output logic [31:0]            i_rdata_o,
  output logic                   i_stallreq_o,
  input  logic                   d_ce_i,
  input  logic                   d_we_i,
  input  logic [31:0]            d_addr_i,
  input  logic [3:0]             d_sel_i,
  input  logic [31:0]            d_wdata_i,
  output logic [31:0]            d_rdata_o,
  output logic                   d_stallreq_o,
  mem_bus_arbiter_if.master      bus,
  output logic                   bus_err_o
);

  arb_state_e  r_state, w_next;
  logic        r_drop;
  logic        r_we;
  logic [31:0] r_addr, r_wdata, r_rbuf_i, r_rbuf_d;
  logic [3:0]  r_sel;
  logic        w_busy, w_ack, w_drop, w_expire;
  logic        w_grant_i, w_grant_d, w_cap_i, w_cap_d;
  logic        w_unused_cfg;

  assign w_busy = arb_on_bus(r_state);
  assign w_ack  = bus.m_ack_i;
  // A flush in the ack cycle itself discards that result just like an earlier one
  assign w_drop = r_drop | flush_i;

`ifdef ARB_TIMEOUT_EN
  arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_busy   (w_busy),
    .i_ack    (w_ack),
    .o_expire (w_expire)
  );
  assign bus_err_o = w_expire;
`else
  assign w_expire  = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  assign w_unused_cfg = ^{stall_i[5], stall_i[3:2], stall_i[0], 16'(TIMEOUT_CYCLES)};

  // State register; async reset abandons any open bus cycle immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) r_state <= ARB_IDLE;
    else                   r_state <= w_next;
  end

  // Next state, grants, read-data mux and capture strobes
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_cap_i   = 1'b0;
    w_cap_d   = 1'b0;
    i_rdata_o = r_rbuf_i;
    d_rdata_o = r_rbuf_d;
    case (r_state)
      ARB_IDLE: begin
        if (d_ce_i && !flush_i) begin
          w_grant_d = 1'b1;
          w_next    = ARB_BUS_D;
        end else if (i_ce_i && !flush_i) begin
          w_grant_i = 1'b1;
          w_next    = ARB_BUS_I;
        end
      end
      ARB_BUS_I: begin
        if (w_ack) begin
          if (!w_drop) begin
            i_rdata_o = bus.m_rdata_i;
            w_cap_i   = 1'b1;
          end
          w_next = (stall_i[STALL_IF] && !w_drop) ? ARB_HOLD_I : ARB_IDLE;
        end else if (w_expire) begin
          i_rdata_o = ZERO_WORD;
          w_next    = ARB_IDLE;
        end
      end
      ARB_BUS_D: begin
        if (w_ack) begin
          if (!w_drop) begin
            d_rdata_o = (r_we == WRITE_ENABLE) ? ZERO_WORD : bus.m_rdata_i;
            w_cap_d   = 1'b1;
          end
          w_next = (stall_i[STALL_MEM] && !w_drop) ? ARB_HOLD_D : ARB_IDLE;
        end else if (w_expire) begin
          d_rdata_o = ZERO_WORD;
          w_next    = ARB_IDLE;
        end
      end
      ARB_HOLD_I: if (!stall_i[STALL_IF] || flush_i)  w_next = ARB_IDLE;
      ARB_HOLD_D: if (!stall_i[STALL_MEM] || flush_i) w_next = ARB_IDLE;
      default:    w_next = ARB_IDLE;
    endcase
  end

  // Drop flag lives only for the bus cycle in which a flush was seen
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) r_drop <= 1'b0;
    else                   r_drop <= w_busy & arb_on_bus(w_next) & w_drop;
  end

  // Bus request registers, loaded at grant and held until the transaction ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_we    <= 1'b0;
      r_addr  <= ZERO_WORD;
      r_sel   <= 4'h0;
      r_wdata <= ZERO_WORD;
    end else if (w_grant_d) begin
      r_we    <= d_we_i;
      r_addr  <= d_addr_i;
      r_sel   <= d_sel_i;
      r_wdata <= d_wdata_i;
    end else if (w_grant_i) begin
      r_we    <= 1'b0;
      r_addr  <= i_addr_i;
      r_sel   <= 4'hF;
    end
  end

  // Read buffers keep the last delivered word while the stage is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_rbuf_i <= ZERO_WORD;
      r_rbuf_d <= ZERO_WORD;
    end else begin
      if (w_cap_i) r_rbuf_i <= i_rdata_o;
      if (w_cap_d) r_rbuf_d <= d_rdata_o;
    end
  end

  assign i_stallreq_o = i_ce_i & ~((r_state == ARB_BUS_I) & (w_ack | w_expire))
                        & ~(r_state == ARB_HOLD_I) & ~flush_i;
  assign d_stallreq_o = d_ce_i & ~((r_state == ARB_BUS_D) & (w_ack | w_expire))
                        & ~(r_state == ARB_HOLD_D) & ~flush_i;

  assign bus.m_cyc_o   = w_busy;
  assign bus.m_stb_o   = w_busy;
  assign bus.m_we_o    = r_we;
  assign bus.m_addr_o  = r_addr;
  assign bus.m_sel_o   = r_sel;
  assign bus.m_wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter with a bus-request scoreboard.
// The timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        i_ce_i, d_ce_i, d_we_i;
  logic [31:0] i_addr_i, d_addr_i, d_wdata_i;
  logic [3:0]  d_sel_i;
  logic [31:0] i_rdata_o, d_rdata_o;
  logic        i_stallreq_o, d_stallreq_o, bus_err_o;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .i_ce_i       (i_ce_i),
    .i_addr_i     (i_addr_i),
    .i_rdata_o    (i_rdata_o),
    .i_stallreq_o (i_stallreq_o),
    .d_ce_i       (d_ce_i),
    .d_we_i       (d_we_i),
    .d_addr_i     (d_addr_i),
    .d_sel_i      (d_sel_i),
    .d_wdata_i    (d_wdata_i),
    .d_rdata_o    (d_rdata_o),
    .d_stallreq_o (d_stallreq_o),
    .bus          (bus.master),
    .bus_err_o    (bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } exp_t;

  exp_t q_exp[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                      input logic [31:0] wdata);
    exp_t e;
    e.we = we; e.addr = addr; e.sel = sel; e.wdata = wdata;
    q_exp.push_back(e);
  endtask

  // Compare the request now on the bus with the oldest expected one
  task automatic pop_check(input string tag);
    chk({tag, "_cyc"}, 32'(bus.m_cyc_o), 32'd1);
    chk({tag, "_stb"}, 32'(bus.m_stb_o), 32'd1);
    n_checks++;
    assert (q_exp.size() != 0) else begin
      n_err++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (q_exp.size() != 0) begin
      cur = q_exp.pop_front();
      chk({tag, "_addr"}, bus.m_addr_o, cur.addr);
      chk({tag, "_we"}, 32'(bus.m_we_o), 32'(cur.we));
      chk({tag, "_sel"}, 32'(bus.m_sel_o), 32'(cur.sel));
      if (cur.we) chk({tag, "_wdata"}, bus.m_wdata_o, cur.wdata);
    end
  endtask

  // Wait (bounded) for the bus cycle, check it, hold wait_n cycles, then ack with rd
  task automatic serve(input string tag, input int wait_n, input logic [31:0] rd);
    int n;
    n = 0;
    do begin tick(); n++; end while (!bus.m_cyc_o && n < 20);
    pop_check(tag);
    for (int k = 0; k < wait_n; k++) begin
      tick();
      chk({tag, "_hold_cyc"}, 32'(bus.m_cyc_o), 32'd1);
      chk({tag, "_hold_addr"}, bus.m_addr_o, cur.addr);
      if (cur.we) chk({tag, "_hold_wdata"}, bus.m_wdata_o, cur.wdata);
    end
    bus.m_ack_i   = 1'b1;
    bus.m_rdata_i = rd;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    rst = 1'b1; stall_i = 6'd0; flush_i = 1'b0;
    i_ce_i = 1'b0; i_addr_i = 32'd0;
    d_ce_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'd0; d_sel_i = 4'h0; d_wdata_i = 32'd0;
    bus.m_ack_i = 1'b0; bus.m_rdata_i = 32'd0;

    // Reset state
    repeat (2) tick();
    chk("rst_cyc", 32'(bus.m_cyc_o), 32'd0);
    chk("rst_addr", bus.m_addr_o, 32'd0);
    chk("rst_i_rdata", i_rdata_o, 32'd0);
    chk("rst_d_rdata", d_rdata_o, 32'd0);
    chk("rst_stallreq", 32'({i_stallreq_o, d_stallreq_o}), 32'd0);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);
    rst = 1'b0;

    // 1: fetch only, ack in second bus cycle
    tick();
    i_ce_i = 1'b1; i_addr_i = 32'h100; push(1'b0, 32'h100, 4'hF, 32'd0);
    #1;
    chk("t1_grant_stall", 32'(i_stallreq_o), 32'd1);
    chk("t1_grant_cyc", 32'(bus.m_cyc_o), 32'd0);
    serve("t1", 1, 32'h3C011234);
    chk("t1_rdata", i_rdata_o, 32'h3C011234);
    chk("t1_stall", 32'(i_stallreq_o), 32'd0);
    chk("t1_bus_err", 32'(bus_err_o), 32'd0);
    tick();
    bus.m_ack_i = 1'b0; i_ce_i = 1'b0;
    #1;
    chk("t1_after_cyc", 32'(bus.m_cyc_o), 32'd0);
    chk("t1_after_rdata", i_rdata_o, 32'h3C011234);

    // 2: collision, data first, fetch after a gap
    tick();
    i_ce_i = 1'b1; i_addr_i = 32'h104;
    d_ce_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200; d_sel_i = 4'hF;
    push(1'b0, 32'h200, 4'hF, 32'd0);
    push(1'b0, 32'h104, 4'hF, 32'd0);
    #1;
    chk("t2_grant_istall", 32'(i_stallreq_o), 32'd1);
    chk("t2_grant_dstall", 32'(d_stallreq_o), 32'd1);
    serve("t2d", 0, 32'h11112222);
    chk("t2d_rdata", d_rdata_o, 32'h11112222);
    chk("t2d_dstall", 32'(d_stallreq_o), 32'd0);
    chk("t2d_istall", 32'(i_stallreq_o), 32'd1);
    tick();
    bus.m_ack_i = 1'b0; d_ce_i = 1'b0;
    #1;
    chk("t2_gap_cyc", 32'(bus.m_cyc_o), 32'd0);
    chk("t2_gap_istall", 32'(i_stallreq_o), 32'd1);
    serve("t2i", 0, 32'h33334444);
    chk("t2i_rdata", i_rdata_o, 32'h33334444);
    chk("t2i_istall", 32'(i_stallreq_o), 32'd0);
    tick();
    bus.m_ack_i = 1'b0; i_ce_i = 1'b0;

    // 3: write, request held stable until ack, read data 0
    d_ce_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h300; d_sel_i = 4'b0011; d_wdata_i = 32'hAABBCCDD;
    push(1'b1, 32'h300, 4'b0011, 32'hAABBCCDD);
    #1;
    serve("t3", 2, 32'h55555555);
    chk("t3_rdata", d_rdata_o, 32'd0);
    chk("t3_dstall", 32'(d_stallreq_o), 32'd0);
    tick();
    bus.m_ack_i = 1'b0; d_ce_i = 1'b0; d_we_i = 1'b0;
    #1;
    chk("t3_after_rdata", d_rdata_o, 32'd0);
    chk("t3_after_cyc", 32'(bus.m_cyc_o), 32'd0);

    // 4: data returned while MEM is held
    tick();
    d_ce_i = 1'b1; d_addr_i = 32'h400; d_sel_i = 4'hF; stall_i = 6'b011111;
    push(1'b0, 32'h400, 4'hF, 32'd0);
    #1;
    serve("t4", 0, 32'hDEADBEEF);
    chk("t4_ack_rdata", d_rdata_o, 32'hDEADBEEF);
    tick();
    bus.m_ack_i = 1'b0; bus.m_rdata_i = 32'd0;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      chk("t4_hold_rdata", d_rdata_o, 32'hDEADBEEF);
      chk("t4_hold_dstall", 32'(d_stallreq_o), 32'd0);
      chk("t4_hold_cyc", 32'(bus.m_cyc_o), 32'd0);
    end
    tick();
    stall_i = 6'd0; d_ce_i = 1'b0;
    #1;
    chk("t4_release_rdata", d_rdata_o, 32'hDEADBEEF);
    tick();
    chk("t4_idle_cyc", 32'(bus.m_cyc_o), 32'd0);
    chk("t4_idle_rdata", d_rdata_o, 32'hDEADBEEF);

    // 5: flush during a fetch cycle, result discarded, fetch re-granted from IDLE
    tick();
    i_ce_i = 1'b1; i_addr_i = 32'h500; push(1'b0, 32'h500, 4'hF, 32'd0);
    #1;
    tick();
    pop_check("t5");
    flush_i = 1'b1;
    #1;
    chk("t5_flush_istall", 32'(i_stallreq_o), 32'd0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("t5_bus_istall", 32'(i_stallreq_o), 32'd1);
    chk("t5_bus_cyc", 32'(bus.m_cyc_o), 32'd1);
    bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'h77777777;
    #1;
    chk("t5_drop_rdata", i_rdata_o, 32'h33334444);
    chk("t5_drop_istall", 32'(i_stallreq_o), 32'd0);
    tick();
    bus.m_ack_i = 1'b0; push(1'b0, 32'h500, 4'hF, 32'd0);
    #1;
    chk("t5_idle_cyc", 32'(bus.m_cyc_o), 32'd0);
    chk("t5_idle_rdata", i_rdata_o, 32'h33334444);
    chk("t5_idle_istall", 32'(i_stallreq_o), 32'd1);
    serve("t5b", 0, 32'h88888888);
    chk("t5b_rdata", i_rdata_o, 32'h88888888);
    tick();
    bus.m_ack_i = 1'b0; i_ce_i = 1'b0;

    // Spurious ack in IDLE is ignored
    tick();
    bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'hFFFF0000;
    #1;
    chk("spur_cyc", 32'(bus.m_cyc_o), 32'd0);
    chk("spur_d_rdata", d_rdata_o, 32'hDEADBEEF);
    chk("spur_i_rdata", i_rdata_o, 32'h88888888);
    tick();
    bus.m_ack_i = 1'b0;
    #1;
    chk("spur_after_i_rdata", i_rdata_o, 32'h88888888);

    // Async reset in the middle of a bus cycle
    tick();
    i_ce_i = 1'b1; i_addr_i = 32'h700; push(1'b0, 32'h700, 4'hF, 32'd0);
    #1;
    tick();
    pop_check("arst");
    rst = 1'b1;
    #1;
    chk("arst_cyc", 32'(bus.m_cyc_o), 32'd0);
    chk("arst_addr", bus.m_addr_o, 32'd0);
    chk("arst_i_rdata", i_rdata_o, 32'd0);
    chk("arst_d_rdata", d_rdata_o, 32'd0);
    i_ce_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // 6: no ack, watchdog gives up after four bus cycles
    i_ce_i = 1'b1; i_addr_i = 32'h600; push(1'b0, 32'h600, 4'hF, 32'd0);
    #1;
    tick();
    pop_check("t6");
    chk("t6_first_err", 32'(bus_err_o), 32'd0);
    repeat (3) tick();
    chk("t6_bus_err", 32'(bus_err_o), 32'd1);
    chk("t6_istall", 32'(i_stallreq_o), 32'd0);
    chk("t6_rdata", i_rdata_o, 32'd0);
    tick();
    i_ce_i = 1'b0;
    #1;
    chk("t6_after_cyc", 32'(bus.m_cyc_o), 32'd0);
    chk("t6_after_err", 32'(bus_err_o), 32'd0);
`endif

    chk("queue_empty", 32'(q_exp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
